// File: rtl/mips_lite_multicycle_core_pkg.sv
// Shared types and helpers for the MIPS-lite multi-cycle core.
package mips_lite_multicycle_core_pkg;

  typedef enum logic [5:0] {
    OpAdd  = 6'd0,  OpAddi = 6'd1,  OpSub  = 6'd2,  OpSubi = 6'd3,
    OpMul  = 6'd4,  OpMuli = 6'd5,  OpOr   = 6'd6,  OpOri  = 6'd7,
    OpAnd  = 6'd8,  OpAndi = 6'd9,  OpXor  = 6'd10, OpXori = 6'd11,
    OpLdw  = 6'd12, OpStw  = 6'd13, OpBz   = 6'd14, OpBeq  = 6'd15,
    OpJr   = 6'd16, OpHalt = 6'd17
  } opcode_t;

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExec, StMem, StWb, StHalted
  } core_state_t;

  // Instruction field positions
  localparam int unsigned OpMsb = 31;
  localparam int unsigned OpLsb = 26;
  localparam int unsigned RsMsb = 25;
  localparam int unsigned RsLsb = 21;
  localparam int unsigned RtMsb = 20;
  localparam int unsigned RtLsb = 16;
  localparam int unsigned RdMsb = 15;
  localparam int unsigned RdLsb = 11;
  localparam int unsigned ImmMsb = 15;

  // Immediate-form encodings: odd ALU opcodes plus memory and branch ops.
  function automatic logic is_itype(input logic [5:0] op);
    return (op <= 6'd11 && op[0]) || op == OpLdw || op == OpStw || op == OpBz || op == OpBeq;
  endfunction

  // 64-bit sign extension; callers truncate to XLEN/AW (both <= 64).
  function automatic logic [63:0] sext16(input logic [15:0] imm);
    return {{48{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mips_lite_alu.sv
// Combinational ALU: add/sub/mul/or/and/xor; anything else adds (address generation).
module mips_lite_alu
  import mips_lite_multicycle_core_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  opcode_t         op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o
);

  // Register and immediate forms of each operation share one datapath.
  always_comb begin
    case (op_i)
      OpSub, OpSubi: result_o = a_i - b_i;
      OpMul, OpMuli: result_o = a_i * b_i;
      OpOr,  OpOri:  result_o = a_i | b_i;
      OpAnd, OpAndi: result_o = a_i & b_i;
      OpXor, OpXori: result_o = a_i ^ b_i;
      default:       result_o = a_i + b_i;
    endcase
    zero_o = (result_o == '0);
  end

endmodule

// File: rtl/mips_lite_multicycle_core.sv
// Multi-cycle MIPS-lite core: FETCH/DECODE/EXEC/MEM/WB FSM with req/ack memories.
// Optional macro STATS_EN adds per-class retirement counters.
module mips_lite_multicycle_core
  import mips_lite_multicycle_core_pkg::*;
#(
  parameter int unsigned   XLEN     = 32,
  parameter int unsigned   NREGS    = 32,
  parameter int unsigned   AW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            imem_req,
  output logic [AW-1:0]   imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [AW-1:0]   dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            halted,
  output logic            illegal,
  output logic [AW-1:0]   pc_out,
  output logic [31:0]     instr_count,
  output logic [31:0]     cycle_count
`ifdef STATS_EN
  ,
  output logic [31:0]     stat_alu,
  output logic [31:0]     stat_mem,
  output logic [31:0]     stat_ctrl,
  output logic [31:0]     stat_taken
`endif
);

  localparam int unsigned RW = (NREGS > 1) ? $clog2(NREGS) : 1;

  function automatic logic [RW-1:0] ridx(input logic [4:0] f);
    return RW'(32'(f) % NREGS);
  endfunction

  core_state_t     state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d, dmem_addr_q, dmem_addr_d;
  logic [31:0]     ir_q, ir_d, icnt_q, icnt_d, ccnt_q, ccnt_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, res_q, res_d, dmem_wdata_q, dmem_wdata_d;
  logic            imem_req_q, imem_req_d, dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
  logic            halted_q, halted_d, illegal_q, illegal_d, retire;
  logic [XLEN-1:0] regs_q [NREGS];
  logic            rf_we;
  logic [RW-1:0]   rf_waddr, rs_idx, rt_idx, rd_idx;

  logic [5:0]      op;
  logic            is_alu;
  logic [XLEN-1:0] imm_x, alu_b, alu_res;
  logic [AW-1:0]   imm_aw, mem_addr;
  opcode_t         alu_op;
  logic            alu_zero;

  assign op       = ir_q[OpMsb:OpLsb];
  assign rs_idx   = ridx(ir_q[RsMsb:RsLsb]);
  assign rt_idx   = ridx(ir_q[RtMsb:RtLsb]);
  assign rd_idx   = ridx(ir_q[RdMsb:RdLsb]);
  assign imm_x    = XLEN'(sext16(ir_q[ImmMsb:0]));
  assign imm_aw   = AW'(sext16(ir_q[ImmMsb:0]));
  assign is_alu   = (op <= 6'd11);
  assign mem_addr = {dmem_addr_d_raw()};

  function automatic logic [AW-1:0] dmem_addr_d_raw();
    logic [AW-1:0] t;
    t = AW'(alu_res);
    t[1:0] = 2'b00;
    return t;
  endfunction

  // Operand/op select: branches compare via subtraction, immediates replace rt.
  always_comb begin
    alu_op = opcode_t'(op);
    alu_b  = b_q;
    if (op == OpBz) begin
      alu_op = OpSub;
      alu_b  = '0;
    end else if (op == OpBeq) begin
      alu_op = OpSub;
    end else if (is_itype(op)) begin
      alu_b = imm_x;
    end
  end

  mips_lite_alu #(
    .XLEN(XLEN)
  ) u_alu (
    .op_i    (alu_op),
    .a_i     (a_q),
    .b_i     (alu_b),
    .result_o(alu_res),
    .zero_o  (alu_zero)
  );

  // Next-state, datapath and registered-output logic of the sequencer.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    imem_req_d   = imem_req_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    halted_d     = halted_q;
    illegal_d    = illegal_q;
    icnt_d       = icnt_q;
    ccnt_d       = ccnt_q;
    retire       = 1'b0;
    rf_we        = 1'b0;
    rf_waddr     = is_itype(op) ? rt_idx : rd_idx;
    if (state_q != StIdle && state_q != StHalted) ccnt_d = ccnt_q + 32'd1;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StFetch;
          pc_d       = RESET_PC;
          imem_req_d = 1'b1;
        end
      end
      StFetch: begin
        if (imem_ack) begin
          ir_d       = imem_rdata;
          imem_req_d = 1'b0;
          state_d    = StDecode;
        end
      end
      StDecode: begin
        a_d     = regs_q[rs_idx];
        b_d     = regs_q[rt_idx];
        state_d = StExec;
      end
      StExec: begin
        pc_d = pc_q + AW'(4);
        if (is_alu) begin
          res_d   = alu_res;
          state_d = StWb;
        end else begin
          case (op)
            OpLdw, OpStw: begin
              dmem_req_d   = 1'b1;
              dmem_we_d    = (op == OpStw);
              dmem_addr_d  = mem_addr;
              dmem_wdata_d = b_q;
              state_d      = StMem;
            end
            OpBz, OpBeq: begin
              if (alu_zero) pc_d = pc_q + (imm_aw << 2);
              state_d    = StFetch;
              imem_req_d = 1'b1;
              retire     = 1'b1;
            end
            OpJr: begin
              pc_d       = AW'(a_q);
              state_d    = StFetch;
              imem_req_d = 1'b1;
              retire     = 1'b1;
            end
            OpHalt: begin
              halted_d = 1'b1;
              state_d  = StHalted;
              retire   = 1'b1;
            end
            default: begin
              illegal_d = 1'b1;
              halted_d  = 1'b1;
              state_d   = StHalted;
              retire    = 1'b1;
            end
          endcase
        end
      end
      StMem: begin
        if (dmem_ack) begin
          dmem_req_d = 1'b0;
          if (dmem_we_q) begin
            state_d    = StFetch;
            imem_req_d = 1'b1;
            retire     = 1'b1;
          end else begin
            res_d   = dmem_rdata;
            state_d = StWb;
          end
        end
      end
      StWb: begin
        rf_we      = 1'b1;
        state_d    = StFetch;
        imem_req_d = 1'b1;
        retire     = 1'b1;
      end
      StHalted: ;
      default: state_d = StIdle;
    endcase
    if (retire) icnt_d = icnt_q + 32'd1;
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      ir_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      imem_req_q   <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      halted_q     <= 1'b0;
      illegal_q    <= 1'b0;
      icnt_q       <= '0;
      ccnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      a_q          <= a_d;
      b_q          <= b_d;
      res_q        <= res_d;
      imem_req_q   <= imem_req_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      halted_q     <= halted_d;
      illegal_q    <= illegal_d;
      icnt_q       <= icnt_d;
      ccnt_q       <= ccnt_d;
    end
  end

  // Register file; written only from WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (rf_we) begin
      regs_q[rf_waddr] <= res_q;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign dmem_req    = dmem_req_q;
  assign dmem_we     = dmem_we_q;
  assign dmem_addr   = dmem_addr_q;
  assign dmem_wdata  = dmem_wdata_q;
  assign halted      = halted_q;
  assign illegal     = illegal_q;
  assign pc_out      = pc_q;
  assign instr_count = icnt_q;
  assign cycle_count = ccnt_q;

`ifdef STATS_EN
  logic [31:0] st_alu_q, st_alu_d, st_mem_q, st_mem_d, st_ctrl_q, st_ctrl_d, st_tkn_q, st_tkn_d;

  // Classify each retirement; JR always counts as taken.
  always_comb begin
    st_alu_d  = st_alu_q;
    st_mem_d  = st_mem_q;
    st_ctrl_d = st_ctrl_q;
    st_tkn_d  = st_tkn_q;
    if (retire) begin
      if (is_alu) st_alu_d = st_alu_q + 32'd1;
      else if (op == OpLdw || op == OpStw) st_mem_d = st_mem_q + 32'd1;
      else if (op == OpBz || op == OpBeq || op == OpJr || op == OpHalt)
        st_ctrl_d = st_ctrl_q + 32'd1;
      if (state_q == StExec && (op == OpJr || ((op == OpBz || op == OpBeq) && alu_zero)))
        st_tkn_d = st_tkn_q + 32'd1;
    end
  end

  // Statistics counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_alu_q  <= '0;
      st_mem_q  <= '0;
      st_ctrl_q <= '0;
      st_tkn_q  <= '0;
    end else begin
      st_alu_q  <= st_alu_d;
      st_mem_q  <= st_mem_d;
      st_ctrl_q <= st_ctrl_d;
      st_tkn_q  <= st_tkn_d;
    end
  end

  assign stat_alu   = st_alu_q;
  assign stat_mem   = st_mem_q;
  assign stat_ctrl  = st_ctrl_q;
  assign stat_taken = st_tkn_q;
`endif

endmodule

// File: tb/tb_mips_lite_multicycle_core.sv
// Bench for mips_lite_multicycle_core: memory responders with programmable ack delay,
// fetch-address and data-access scoreboards, and end-of-program counter checks.
module tb_mips_lite_multicycle_core;

  localparam logic [5:0] OpAdd = 6'd0, OpAddi = 6'd1, OpMul = 6'd4, OpLdw = 6'd12,
                         OpStw = 6'd13, OpBz = 6'd14, OpBeq = 6'd15, OpJr = 6'd16,
                         OpHalt = 6'd17;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } dm_t;

  logic        clk, rst_n, start;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, halted, illegal;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0] pc_out, instr_count, cycle_count;
`ifdef STATS_EN
  logic [31:0] stat_alu, stat_mem, stat_ctrl, stat_taken;
`endif

  logic [31:0] imem [256];
  logic [31:0] dmem [256];
  logic [31:0] fetch_q [$];
  dm_t         dm_q [$];
  int          idelay, ddelay;
  int          n_checks, n_fail;

  mips_lite_multicycle_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .halted     (halted),
    .illegal    (illegal),
    .pc_out     (pc_out),
    .instr_count(instr_count),
    .cycle_count(cycle_count)
`ifdef STATS_EN
    ,
    .stat_alu   (stat_alu),
    .stat_mem   (stat_mem),
    .stat_ctrl  (stat_ctrl),
    .stat_taken (stat_taken)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ri(input logic [5:0] op, input int rs, input int rt,
                                     input int rd);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] ii(input logic [5:0] op, input int rs, input int rt,
                                     input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  // Instruction memory: acks after idelay wait cycles and checks the fetch address.
  task automatic imem_proc();
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (imem_req && !imem_ack && rst_n) begin
        if (cnt >= idelay) begin
          imem_ack   = 1'b1;
          imem_rdata = imem[imem_addr[9:2]];
          cnt        = 0;
          if (fetch_q.size() == 0) check_eq("fetch_unexpected", 1, 0);
          else check_eq("fetch_pc", imem_addr, fetch_q.pop_front());
        end else cnt++;
      end else begin
        imem_ack = 1'b0;
        cnt      = 0;
      end
    end
  endtask

  // Data memory: acks after ddelay wait cycles and checks each access.
  task automatic dmem_proc();
    int          cnt = 0;
    logic [31:0] first = '0;
    dm_t         e;
    forever begin
      @(negedge clk);
      if (dmem_req && !dmem_ack && rst_n) begin
        if (cnt == 0) first = dmem_addr;
        if (cnt >= ddelay) begin
          dmem_ack = 1'b1;
          if (cnt > 0) check_eq("dmem_addr_hold", dmem_addr, first);
          if (dmem_we) dmem[dmem_addr[9:2]] = dmem_wdata;
          else dmem_rdata = dmem[dmem_addr[9:2]];
          if (dm_q.size() == 0) check_eq("dmem_unexpected", 1, 0);
          else begin
            e = dm_q.pop_front();
            check_eq("dmem_we", dmem_we, e.we);
            check_eq("dmem_addr", dmem_addr, e.addr);
            if (e.we) check_eq("dmem_wdata", dmem_wdata, e.data);
          end
          cnt = 0;
        end else cnt++;
      end else begin
        dmem_ack = 1'b0;
        cnt      = 0;
      end
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      imem[i] = '0;
      dmem[i] = '0;
    end
    fetch_q.delete();
    dm_q.delete();
    idelay = 0;
    ddelay = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push_dm(input logic we, input logic [31:0] addr, input logic [31:0] data);
    dm_t e;
    e.we = we;
    e.addr = addr;
    e.data = data;
    dm_q.push_back(e);
  endtask

  task automatic run_prog(input int limit);
    int n = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    while (!halted && n < limit) begin
      @(negedge clk);
      n++;
    end
    check_eq("halt_reached", halted, 1);
    check_eq("fetch_q_drained", fetch_q.size(), 0);
    check_eq("dmem_q_drained", dm_q.size(), 0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    imem_rdata = '0;
    dmem_rdata = '0;
    rst_n = 1'b0;
    start = 1'b0;
    idelay = 0;
    ddelay = 0;
    fork
      imem_proc();
      dmem_proc();
    join_none

    // Reset and idle with start low
    apply_reset();
    repeat (10) @(negedge clk);
    check_eq("rst_imem_req", imem_req, 0);
    check_eq("rst_imem_addr", imem_addr, 0);
    check_eq("rst_dmem_req", dmem_req, 0);
    check_eq("rst_dmem_we", dmem_we, 0);
    check_eq("rst_dmem_addr", dmem_addr, 0);
    check_eq("rst_dmem_wdata", dmem_wdata, 0);
    check_eq("rst_halted", halted, 0);
    check_eq("rst_illegal", illegal, 0);
    check_eq("rst_pc", pc_out, 0);
    check_eq("rst_instr_count", instr_count, 0);
    check_eq("rst_cycle_count", cycle_count, 0);

    // ALU: 5 * -3 stored to 0x20; cycles = 3 ALU x4 + STW 4 + HALT 3 = 19
    apply_reset();
    imem[0] = ii(OpAddi, 0, 1, 5);
    imem[1] = ii(OpAddi, 0, 2, -3);
    imem[2] = ri(OpMul, 1, 2, 3);
    imem[3] = ii(OpStw, 0, 3, 32'h20);
    imem[4] = {OpHalt, 26'd0};
    for (int i = 0; i < 5; i++) fetch_q.push_back(32'(4 * i));
    push_dm(1'b1, 32'h20, 32'hFFFF_FFF1);
    run_prog(200);
    check_eq("alu_instr_count", instr_count, 5);
    check_eq("alu_cycle_count", cycle_count, 19);
    check_eq("alu_pc", pc_out, 32'h14);
    check_eq("alu_illegal", illegal, 0);
    repeat (5) @(negedge clk);
    check_eq("halted_cycles_frozen", cycle_count, 19);
    check_eq("halted_sticky", halted, 1);

    // Memory waits: imem +2, dmem +3 per access; cycles = 20 + 5*2 + 3*3 = 39
    apply_reset();
    idelay = 2;
    ddelay = 3;
    imem[0] = ii(OpAddi, 0, 1, 5);
    imem[1] = ii(OpStw, 0, 1, 32'h10);
    imem[2] = ii(OpLdw, 0, 4, 32'h12);
    imem[3] = ii(OpStw, 0, 4, 32'h30);
    imem[4] = {OpHalt, 26'd0};
    for (int i = 0; i < 5; i++) fetch_q.push_back(32'(4 * i));
    push_dm(1'b1, 32'h10, 32'd5);
    push_dm(1'b0, 32'h10, 32'd0);
    push_dm(1'b1, 32'h30, 32'd5);
    run_prog(400);
    check_eq("mem_instr_count", instr_count, 5);
    check_eq("mem_cycle_count", cycle_count, 39);

    // Branches: BEQ taken, BZ not taken, JR, BZ taken; cycles = 4+4+3*5 = 23
    apply_reset();
    imem[0]  = ii(OpAddi, 0, 1, 5);
    imem[1]  = ii(OpAddi, 0, 5, 32'h40);
    imem[2]  = ii(OpBeq, 1, 1, 2);
    imem[3]  = 32'hFC00_0000;
    imem[4]  = ii(OpBz, 1, 0, 4);
    imem[5]  = {OpJr, 5'd5, 21'd0};
    imem[16] = ii(OpBz, 0, 0, 2);
    imem[17] = 32'hFC00_0000;
    imem[18] = {OpHalt, 26'd0};
    fetch_q = '{32'h0, 32'h4, 32'h8, 32'h10, 32'h14, 32'h40, 32'h48};
    run_prog(300);
    check_eq("br_instr_count", instr_count, 7);
    check_eq("br_cycle_count", cycle_count, 23);
    check_eq("br_pc", pc_out, 32'h4C);
    check_eq("br_illegal", illegal, 0);

    // Illegal opcode halts without a further fetch or data access
    apply_reset();
    imem[0] = ii(OpAddi, 0, 1, 7);
    imem[1] = 32'hFC20_0000;
    fetch_q = '{32'h0, 32'h4};
    run_prog(200);
    check_eq("ill_illegal", illegal, 1);
    check_eq("ill_cycle_count", cycle_count, 7);
    repeat (4) @(negedge clk);
    check_eq("ill_stays_halted", halted, 1);

    // Reset pulse mid-FETCH drops imem_req immediately; restart fetches RESET_PC
    apply_reset();
    idelay = 3;
    imem[0] = ii(OpAddi, 0, 1, 1);
    imem[1] = {OpHalt, 26'd0};
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check_eq("mid_fetch_req", imem_req, 1);
    #2 rst_n = 1'b0;
    #1 check_eq("async_req_drop", imem_req, 0);
    check_eq("async_pc_reset", pc_out, 0);
    @(negedge clk) rst_n = 1'b1;
    idelay = 0;
    fetch_q = '{32'h0, 32'h4};
    run_prog(200);
    check_eq("restart_instr_count", instr_count, 2);
    check_eq("restart_cycle_count", cycle_count, 7);
    check_eq("restart_pc", pc_out, 32'h8);

`ifdef STATS_EN
    // Mix: 3 ALU, 2 memory, BZ not taken, BEQ taken, HALT
    apply_reset();
    imem[0] = ii(OpAddi, 0, 1, 4);
    imem[1] = ii(OpAddi, 0, 2, 8);
    imem[2] = ri(OpAdd, 1, 2, 3);
    imem[3] = ii(OpStw, 0, 3, 0);
    imem[4] = ii(OpLdw, 0, 6, 0);
    imem[5] = ii(OpBz, 1, 0, 4);
    imem[6] = ii(OpBeq, 1, 1, 1);
    imem[7] = {OpHalt, 26'd0};
    for (int i = 0; i < 8; i++) fetch_q.push_back(32'(4 * i));
    push_dm(1'b1, 32'h0, 32'd12);
    push_dm(1'b0, 32'h0, 32'd0);
    run_prog(300);
    check_eq("stat_alu", stat_alu, 3);
    check_eq("stat_mem", stat_mem, 2);
    check_eq("stat_ctrl", stat_ctrl, 3);
    check_eq("stat_taken", stat_taken, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
